meta_streamer: RTL

//   Next-generation metadata responder. On a metadata query it streams the
//   TLV metadata block into the spi_transmitter datapath one byte at a time,

---
 rtl/meta_streamer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/meta_streamer.sv
// Metadata responder: streams a constant TLV block, with runtime fields patched
// from snapshotted inputs, one byte per transmitter-idle handshake.
module meta_streamer #(
    parameter int ADDR_W      = 6,
    parameter int META_LEN    = 47,
    parameter int MEMSIZE_OFS = 33,
    parameter int RATE_OFS    = 38,
    parameter int PROBES_OFS  = 43
) (
    input  logic        clock,
    input  logic        extReset_n,
    input  logic        query_metadata,
    input  logic        abort,
    input  logic        xmit_idle,
    input  logic [31:0] mem_size,
    input  logic [31:0] sample_rate,
    input  logic [7:0]  probe_count,
    output logic        writeMeta,
    output logic [7:0]  meta_data,
    output logic        busy,
    output logic        done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_INDEX = (ADDR_W + 1)'(META_LEN);

    generate
        if (META_LEN < 1 || META_LEN > DEPTH) begin : g_len_check
            $error("meta_streamer: META_LEN must lie in 1..2**ADDR_W");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LOAD, SEND, POLL, DONE} state_t;

    // Payload bytes of the patched TLVs are left 0 here; they come from the snapshot.
    function automatic logic [7:0] rom_const(input int a);
        logic [7:0] b;
        b = 8'h00;
        case (a)
            0:  b = 8'h01;
            1:  b = "O";  2:  b = "p";  3:  b = "e";  4:  b = "n";
            5:  b = " ";  6:  b = "L";  7:  b = "o";  8:  b = "g";
            9:  b = "i";  10: b = "c";  11: b = " ";  12: b = "S";
            13: b = "n";  14: b = "i";  15: b = "f";  16: b = "f";
            17: b = "e";  18: b = "r";  19: b = 8'h00;
            20: b = 8'h02;
            21: b = "F";  22: b = "P";  23: b = "G";  24: b = "A";
            25: b = " ";  26: b = "v";  27: b = "3";  28: b = ".";
            29: b = "0";  30: b = "7";  31: b = 8'h00;
            32: b = 8'h21;
            37: b = 8'h23;
            42: b = 8'h40;
            44: b = 8'h41;
            45: b = 8'h02;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [7:0] rom [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign rom[gi] = rom_const(gi);
        end
    endgenerate

    state_t          state_reg, state_next;
    logic [ADDR_W:0] index_reg, index_next;
    logic [31:0]     mem_size_snap_reg, mem_size_snap_next;
    logic [31:0]     rate_snap_reg, rate_snap_next;
    logic [7:0]      probes_snap_reg, probes_snap_next;
    logic            write_meta_reg, write_meta_next;
    logic [7:0]      meta_data_reg, meta_data_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic [7:0]      send_byte;

    // Big-endian overlay of the snapshotted runtime fields onto the ROM byte.
    always_comb begin
        send_byte = rom[index_reg[ADDR_W-1:0]];
        for (int k = 0; k < 4; k++) begin
            if (index_reg == (ADDR_W + 1)'(MEMSIZE_OFS + k))
                send_byte = mem_size_snap_reg[31-8*k -: 8];
            if (index_reg == (ADDR_W + 1)'(RATE_OFS + k))
                send_byte = rate_snap_reg[31-8*k -: 8];
        end
        if (index_reg == (ADDR_W + 1)'(PROBES_OFS))
            send_byte = probes_snap_reg;
    end

    always_comb begin
        state_next         = state_reg;
        index_next         = index_reg;
        mem_size_snap_next = mem_size_snap_reg;
        rate_snap_next     = rate_snap_reg;
        probes_snap_next   = probes_snap_reg;
        write_meta_next    = 1'b0;
        meta_data_next     = meta_data_reg;
        busy_next          = busy_reg;
        done_next          = 1'b0;
        case (state_reg)
            IDLE: begin
                index_next = '0;
                busy_next  = 1'b0;
                if (query_metadata && xmit_idle && !abort) begin
                    state_next = LOAD;
                    busy_next  = 1'b1;
                end
            end
            LOAD: begin
                mem_size_snap_next = mem_size;
                rate_snap_next     = sample_rate;
                probes_snap_next   = probe_count;
                if (abort) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    write_meta_next = 1'b1;
                    meta_data_next  = send_byte;
                    index_next      = index_reg + 1'b1;
                    state_next      = POLL;
                end
            end
            POLL: begin
                if (abort) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else if (xmit_idle) begin
                    if (index_reg == LAST_INDEX) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = SEND;
                    end
                end
            end
            DONE: begin
                // busy drops one cycle after the done pulse
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            state_reg         <= IDLE;
            index_reg         <= '0;
            mem_size_snap_reg <= '0;
            rate_snap_reg     <= '0;
            probes_snap_reg   <= '0;
            write_meta_reg    <= 1'b0;
            meta_data_reg     <= 8'h00;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            index_reg         <= index_next;
            mem_size_snap_reg <= mem_size_snap_next;
            rate_snap_reg     <= rate_snap_next;
            probes_snap_reg   <= probes_snap_next;
            write_meta_reg    <= write_meta_next;
            meta_data_reg     <= meta_data_next;
            busy_reg          <= busy_next;
            done_reg          <= done_next;
        end
    end

    assign writeMeta = write_meta_reg;
    assign meta_data = meta_data_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
